elastic_skid_fifo: RTL

- Parametrised successor to the single-entry skid buffer: a valid/ready elastic buffer with a DEPTH-entry ring plus a registered output stage.
- Fully registered outputs; no combinational path from i_ready to o_ready or from i_valid to o_valid.
- Sits between pipeline stages that need more than one cycle of slack, e.g. across long routes or bursty consumers.
- Also reports occupancy for upstream flow control and debug.

---
 rtl/elastic_skid_fifo_if.sv | 42 ++++
 rtl/elastic_skid_fifo.sv | 103 ++++++++++
 2 files changed

// File: rtl/elastic_skid_fifo_if.sv
// elastic_skid_fifo_if: valid/ready bus for elastic_skid_fifo; i_flush exists only with ELASTIC_SKID_FLUSH_EN.
// Rev 1.0
`default_nettype none

interface elastic_skid_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
`ifdef ELASTIC_SKID_FLUSH_EN
  logic          i_flush;

  modport master (
    output i_valid, i_data, i_ready, i_flush,
    input  o_ready, o_valid, o_data, o_count
  );
  modport slave (
    input  i_valid, i_data, i_ready, i_flush,
    output o_ready, o_valid, o_data, o_count
  );
`else
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/elastic_skid_fifo.sv
// elastic_skid_fifo: DEPTH-entry ring plus registered output stage, capacity DEPTH+1, fully registered outputs.
// Rev 1.0 -- optional synchronous flush enabled by ELASTIC_SKID_FLUSH_EN.
`default_nettype none

module elastic_skid_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  elastic_skid_fifo_if.slave bus
);
  localparam int            CW    = $clog2(DEPTH) + 1;
  localparam int            AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] c_cap = CW'(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;

  logic          w_accept;
  logic          w_pop;
  logic          w_load;
  logic [CW-1:0] w_ring_cnt;
  logic          w_ring_empty;
  logic          w_ring_wr;
  logic [CW-1:0] w_count_nxt;

`ifdef ELASTIC_SKID_FLUSH_EN
  assign w_accept = bus.i_valid && r_ready && !bus.i_flush;
  assign w_pop    = r_valid && bus.i_ready && !bus.i_flush;
`else
  assign w_accept = bus.i_valid && r_ready;
  assign w_pop    = r_valid && bus.i_ready;
`endif

  // The output register is always filled before the ring, so the ring holds count minus o_valid.
  assign w_ring_cnt   = r_count - CW'(r_valid);
  assign w_ring_empty = (w_ring_cnt == '0);
  assign w_load       = !r_valid || bus.i_ready;
  assign w_ring_wr    = w_accept && !(w_load && w_ring_empty);
  assign w_count_nxt  = r_count + CW'(w_accept) - CW'(w_pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_data   <= '0;
    end
`ifdef ELASTIC_SKID_FLUSH_EN
    else if (bus.i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
      r_data   <= '0;
    end
`endif
    else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < c_cap);
      if (w_ring_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        if (!w_ring_empty) begin
          r_data   <= r_mem[r_rd_ptr];
          r_valid  <= 1'b1;
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end else if (w_accept) begin
          r_data  <= bus.i_data;
          r_valid <= 1'b1;
        end else begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end
      end
    end
  end

  // Storage needs no reset: contents are only read when the count says they are valid.
  always_ff @(posedge i_clk) begin
    if (w_ring_wr) begin
      r_mem[r_wr_ptr] <= bus.i_data;
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_count = r_count;

endmodule

`default_nettype wire
